hive_stack_ctl: RTL
===================

HIVE_STACK_CTL -- requirements
Module: hive_stack_ctl

Parameters
REQ-001 The block SHALL have parameter THREADS, default 8, meaning number of interleaved threads.
REQ-002 The block SHALL have parameter ID_W, default 3, meaning thread id width (2^ID_W = THREADS).
REQ-003 The block SHALL have parameter STACKS, default 8, meaning stacks per thread.
REQ-004 The block SHALL have parameter STK_W, default 3, meaning stack selector width.
REQ-005 The block SHALL have parameter DEPTH, default 32, meaning entries per stack.
REQ-006 The block SHALL have parameter LVL_W, default 6, meaning level counter width (holds 0..DEPTH).

Interface
REQ-007 The block SHALL have clk_i, input, 1, the single clock; all state SHALL be on its rising edge.
REQ-008 The block SHALL have rst_n_i, input, 1, reset, asynchronous and active-low.
REQ-009 The block SHALL have vld_i, input, 1, request valid this cycle.
REQ-010 The block SHALL have id_i, input, ID_W, thread of the request.
REQ-011 The block SHALL have cls_i, input, STACKS, per-stack clear.
REQ-012 The block SHALL have sa_i / sb_i, input, STK_W each, stack A / B selectors.
REQ-013 The block SHALL have pa_i / pb_i, input, 1 each, pop stack sa_i / sb_i.
REQ-014 The block SHALL have psh_i, input, 1, push to stack sa_i.
REQ-015 The block SHALL have cls_o / pop_o / psh_o, output, STACKS each, qualified per-stack commands to the stack storage.
REQ-016 The block SHALL have id_o, output, ID_W, thread of the registered commands.
REQ-017 The block SHALL have lvl_a_o, output, LVL_W, pre-operation level of stack sa_i.
REQ-018 The block SHALL have pop_er_o / psh_er_o, output, 1 each, pop-when-empty / push-when-full pulses.
REQ-019 The block SHALL have er_cnt_o, output, 16, saturating total error count.

Function
REQ-020 The block SHALL hold one level counter per (thread, stack) pair, THREADS*STACKS counters of LVL_W bits each.
REQ-021 With vld_i low, no counter SHALL change and cls_o, pop_o, psh_o, pop_er_o and psh_er_o SHALL be 0 next cycle.
REQ-022 For stack s, pop_req SHALL be (pa_i and sa_i==s) or (pb_i and sb_i==s).
REQ-023 When pa_i and pb_i select the same stack, the block SHALL count one pop only.
REQ-024 For stack s, psh_req SHALL be psh_i and sa_i==s.
REQ-025 cls_i[s] SHALL set level to 0, assert cls_o[s], suppress that stack's pop and push, and flag no error.
REQ-026 pop_req at level 0 SHALL suppress the pop, assert pop_er_o, and still allow a coincident push (level becomes 1).
REQ-027 psh_req at level DEPTH without pop_req SHALL suppress the push and assert psh_er_o.
REQ-028 pop_req and psh_req together at level 1..DEPTH SHALL pass both commands with level unchanged (pop before push).
REQ-029 Otherwise a pop SHALL decrement the level by 1, a push SHALL increment it by 1, and the level SHALL never leave 0..DEPTH.
REQ-030 Latency SHALL be 1 cycle: request sampled at edge N; counter update and registered outputs (cls_o, pop_o, psh_o, id_o, lvl_a_o, error pulses) valid after edge N.
REQ-031 Back-to-back requests for the same id SHALL see the previous cycle's updated level with no hazard.
REQ-032 pop_er_o and psh_er_o SHALL be single-cycle pulses; both MAY assert in the same cycle.
REQ-033 er_cnt_o SHALL increment by the number of error bits asserted that cycle (0, 1 or 2) and saturate at 0xFFFF.

Reset
REQ-034 While rst_n_i is low, all level counters, all outputs and er_cnt_o SHALL be 0, taking effect immediately without a clock.
REQ-035 A request coincident with reset deassertion SHALL be ignored; the first request SHALL be sampled on the first edge with rst_n_i high.
REQ-036 Reset asserted mid-stream SHALL discard all levels; after release every stack SHALL read empty.

Verification
REQ-037 Reset, then id=2, psh_i=1, sa_i=5 -> next cycle psh_o=0x20, id_o=2, lvl_a_o=0; a second push on the same stack reports lvl_a_o=1.
REQ-038 id=0, pa_i=1, sa_i=3 on an empty stack -> pop_o=0, pop_er_o=1, er_cnt_o=1.
REQ-039 32 pushes to id=1, stack 0, then a 33rd push -> psh_er_o=1, psh_o=0; then push and pop together -> pop_o=0x01, psh_o=0x01, level stays 32.
REQ-040 id=4 with stack 2 at level 3: pa_i=pb_i=1, sa_i=sb_i=2 -> pop_o=0x04, level 2; then cls_i=0x04 with psh_i=1, sa_i=2 -> cls_o=0x04, psh_o=0, level 0.
REQ-041 Force 0xFFFF errors, then one more pop on an empty stack -> er_cnt_o stays 0xFFFF; then pulse rst_n_i low with no clock -> all outputs 0 at once.

Source files
------------

// File: rtl/hive_stack_ctl.sv
// hive_stack_ctl: per-thread stack level tracking and command qualification.
// One registered cycle from request to qualified push/pop/clear commands.
module hive_stack_ctl #(
  parameter int THREADS = 8,
  parameter int ID_W    = 3,
  parameter int STACKS  = 8,
  parameter int STK_W   = 3,
  parameter int DEPTH   = 32,
  parameter int LVL_W   = 6
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              vld_i,
  input  logic [ID_W-1:0]   id_i,
  input  logic [STACKS-1:0] cls_i,
  input  logic [STK_W-1:0]  sa_i,
  input  logic [STK_W-1:0]  sb_i,
  input  logic              pa_i,
  input  logic              pb_i,
  input  logic              psh_i,
  output logic [STACKS-1:0] cls_o,
  output logic [STACKS-1:0] pop_o,
  output logic [STACKS-1:0] psh_o,
  output logic [ID_W-1:0]   id_o,
  output logic [LVL_W-1:0]  lvl_a_o,
  output logic              pop_er_o,
  output logic              psh_er_o,
  output logic [15:0]       er_cnt_o
);

  logic [LVL_W-1:0]  lvl_q [THREADS][STACKS];
  logic [LVL_W-1:0]  lvl_d [THREADS][STACKS];
  logic [LVL_W-1:0]  cur_lvl [STACKS];
  logic [STACKS-1:0] pop_req, psh_req, emp, ful;

  logic [STACKS-1:0] cls_d, cls_q;
  logic [STACKS-1:0] pop_d, pop_q;
  logic [STACKS-1:0] psh_d, psh_q;
  logic [ID_W-1:0]   id_d, id_q;
  logic [LVL_W-1:0]  lvl_a_d, lvl_a_q;
  logic              pop_er_d, pop_er_q;
  logic              psh_er_d, psh_er_q;
  logic [15:0]       er_cnt_d, er_cnt_q;
  logic [1:0]        er_inc;
  logic [16:0]       er_sum;

  always_comb begin
    for (int s = 0; s < STACKS; s++) begin
      pop_req[s] = (pa_i && sa_i == STK_W'(s)) ||
                   (pb_i && sb_i == STK_W'(s));
      psh_req[s] = psh_i && sa_i == STK_W'(s);
      cur_lvl[s] = lvl_q[id_i][s];
      emp[s]     = cur_lvl[s] == '0;
      ful[s]     = cur_lvl[s] == LVL_W'(DEPTH);
    end
  end

  always_comb begin
    lvl_d    = lvl_q;
    cls_d    = '0;
    pop_d    = '0;
    psh_d    = '0;
    pop_er_d = 1'b0;
    psh_er_d = 1'b0;
    id_d     = id_q;
    lvl_a_d  = lvl_a_q;
    if (vld_i) begin
      id_d    = id_i;
      lvl_a_d = cur_lvl[sa_i];
      for (int s = 0; s < STACKS; s++) begin
        if (cls_i[s]) begin
          cls_d[s] = 1'b1;
          lvl_d[id_i][s] = '0;
        end else begin
          // a full stack still accepts a push when a pop frees the slot
          pop_d[s] = pop_req[s] && !emp[s];
          psh_d[s] = psh_req[s] && (!ful[s] || pop_req[s]);
          lvl_d[id_i][s] = cur_lvl[s] + LVL_W'(psh_d[s])
                           - LVL_W'(pop_d[s]);
        end
      end
      pop_er_d = |(pop_req & emp & ~cls_i);
      psh_er_d = |(psh_req & ful & ~pop_req & ~cls_i);
    end
  end

  always_comb begin
    er_inc   = {1'b0, pop_er_d} + {1'b0, psh_er_d};
    er_sum   = {1'b0, er_cnt_q} + {15'b0, er_inc};
    er_cnt_d = er_sum[16] ? 16'hFFFF : er_sum[15:0];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lvl_q    <= '{default: '0};
      cls_q    <= '0;
      pop_q    <= '0;
      psh_q    <= '0;
      id_q     <= '0;
      lvl_a_q  <= '0;
      pop_er_q <= 1'b0;
      psh_er_q <= 1'b0;
      er_cnt_q <= '0;
    end else begin
      lvl_q    <= lvl_d;
      cls_q    <= cls_d;
      pop_q    <= pop_d;
      psh_q    <= psh_d;
      id_q     <= id_d;
      lvl_a_q  <= lvl_a_d;
      pop_er_q <= pop_er_d;
      psh_er_q <= psh_er_d;
      er_cnt_q <= er_cnt_d;
    end
  end

  assign cls_o    = cls_q;
  assign pop_o    = pop_q;
  assign psh_o    = psh_q;
  assign id_o     = id_q;
  assign lvl_a_o  = lvl_a_q;
  assign pop_er_o = pop_er_q;
  assign psh_er_o = psh_er_q;
  assign er_cnt_o = er_cnt_q;

endmodule
